// File: rtl/mem_port_arb_if.sv
// Memory-port arbiter bus: I-cache refill side, D-cache side and the shared memory port.
// "slave" is the arbiter's view; "master" is the view of the caches and memory around it.
interface mem_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              im_done;
  logic              dm_done;
  logic [DATA_W-1:0] rdata;
  logic              mem_err;
  logic              stall_cache;

  modport slave (
    input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, im_done, dm_done, rdata, mem_err,
           stall_cache
  );

  modport master (
    output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, im_done, dm_done, rdata, mem_err,
           stall_cache
  );
endinterface

// File: rtl/mem_port_arb.sv
// Two-requester (I-cache refill / D-cache) arbiter for a single memory port,
// with alternating priority, a per-grant timeout and a combinational pipeline stall.
module mem_port_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input logic           clk,
  input logic           rst,
  mem_port_arb_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t            state, state_d;
  side_t             last_gnt, last_gnt_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              im_done_q, im_done_d;
  logic              dm_done_q, dm_done_d;
  logic              mem_err_q, mem_err_d;

  logic im_elig, dm_elig, pick_d, finish;

  // A requester still high during its own done cycle is stale and must not re-win.
  assign im_elig = bus.im_req & ~im_done_q;
  assign dm_elig = bus.dm_req & ~dm_done_q;
  assign pick_d  = dm_elig & (~im_elig | (last_gnt == SIDE_I));
  assign finish  = bus.mem_ready | (wait_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_gnt    <= SIDE_I;
      wait_cnt    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      im_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state       <= state_d;
      last_gnt    <= last_gnt_d;
      wait_cnt    <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      im_done_q   <= im_done_d;
      dm_done_q   <= dm_done_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (pick_d)       state_d = GNT_D;
        else if (im_elig) state_d = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed here as next values; mem_ready wins over a same-cycle timeout.
  always_comb begin
    last_gnt_d  = last_gnt;
    wait_cnt_d  = wait_cnt;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    im_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    mem_err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          wait_cnt_d  = '0;
        end else if (im_elig) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.im_addr;
          mem_wdata_d = '0;
          wait_cnt_d  = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (finish) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          im_done_d  = (state == GNT_I);
          dm_done_d  = (state == GNT_D);
          last_gnt_d = (state == GNT_D) ? SIDE_D : SIDE_I;
          if (bus.mem_ready) rdata_d   = bus.mem_rdata;
          else               mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.im_done     = im_done_q;
  assign bus.dm_done     = dm_done_q;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cache = im_elig | dm_elig;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: one task per scenario, hand-computed expectations.
module tb_mem_port_arb;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_respond(input int wait_cycles, input logic [DW-1:0] data);
    repeat (wait_cycles) tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.im_req = 1'b0; bus.im_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (3) tick();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    checks++; if ({bus.im_done, bus.dm_done, bus.mem_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b expected 000", {bus.im_done, bus.dm_done, bus.mem_err}); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.rdata); end
    checks++; if (bus.stall_cache !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", bus.stall_cache); end
    @(negedge clk);
    rst = 1'b1;
    // stray mem_ready while idle must be ignored
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if ({bus.mem_req, bus.im_done, bus.dm_done, bus.mem_err} !== 4'b0000) begin errors++; $display("FAIL idle_ready_ctl: got %b expected 0000", {bus.mem_req, bus.im_done, bus.dm_done, bus.mem_err}); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL idle_ready_rdata: got %h expected 0", bus.rdata); end
  endtask

  task automatic test_single_i_miss();
    bus.im_addr = 32'h100;
    bus.im_req  = 1'b1;
    #1;
    checks++; if (bus.stall_cache !== 1'b1) begin errors++; $display("FAIL imiss_stall_req: got %b expected 1", bus.stall_cache); end
    tick();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL imiss_mem_req: got %b expected 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL imiss_addr: got %h expected 00000100", bus.mem_addr); end
    checks++; if ({bus.mem_we, bus.mem_wdata} !== 33'h0) begin errors++; $display("FAIL imiss_we_wdata: got %b/%h expected 0/0", bus.mem_we, bus.mem_wdata); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({bus.mem_req, bus.im_done, bus.stall_cache} !== 3'b101) begin errors++; $display("FAIL imiss_wait%0d: got req/done/stall %b expected 101", i, {bus.mem_req, bus.im_done, bus.stall_cache}); end
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if ({bus.im_done, bus.dm_done, bus.mem_err} !== 3'b100) begin errors++; $display("FAIL imiss_done: got im/dm/err %b expected 100", {bus.im_done, bus.dm_done, bus.mem_err}); end
    checks++; if (bus.rdata !== 32'h13) begin errors++; $display("FAIL imiss_rdata: got %h expected 00000013", bus.rdata); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL imiss_req_drop: got %b expected 0", bus.mem_req); end
    checks++; if (bus.stall_cache !== 1'b0) begin errors++; $display("FAIL imiss_stall_done: got %b expected 0", bus.stall_cache); end
    // im_req left high through the done cycle: stale, must not be re-granted
    tick();
    bus.im_req = 1'b0;
    checks++; if ({bus.mem_req, bus.im_done} !== 2'b00) begin errors++; $display("FAIL imiss_stale: got req/done %b expected 00", {bus.mem_req, bus.im_done}); end
    tick();
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    bus.im_addr = 32'h300; bus.im_req = 1'b1;
    bus.dm_addr = 32'h2000; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
    tick();
    checks++; if (bus.mem_addr !== 32'h2000) begin errors++; $display("FAIL sim_first_addr: got %h expected 00002000", bus.mem_addr); end
    checks++; if ({bus.mem_req, bus.mem_we, bus.stall_cache} !== 3'b101) begin errors++; $display("FAIL sim_first_ctl: got req/we/stall %b expected 101", {bus.mem_req, bus.mem_we, bus.stall_cache}); end
    mem_respond(1, 32'hA5A5_0001);
    checks++; if ({bus.dm_done, bus.im_done, bus.mem_req, bus.stall_cache} !== 4'b1001) begin errors++; $display("FAIL sim_d_done: got dm/im/req/stall %b expected 1001", {bus.dm_done, bus.im_done, bus.mem_req, bus.stall_cache}); end
    checks++; if (bus.rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL sim_d_rdata: got %h expected a5a50001", bus.rdata); end
    bus.dm_req = 1'b0;
    tick();
    checks++; if ({bus.mem_req, bus.mem_we, bus.dm_done, bus.stall_cache} !== 4'b1001) begin errors++; $display("FAIL sim_i_grant: got req/we/dmdone/stall %b expected 1001", {bus.mem_req, bus.mem_we, bus.dm_done, bus.stall_cache}); end
    checks++; if (bus.mem_addr !== 32'h300) begin errors++; $display("FAIL sim_i_addr: got %h expected 00000300", bus.mem_addr); end
    mem_respond(0, 32'h0000_0011);
    checks++; if ({bus.im_done, bus.dm_done} !== 2'b10) begin errors++; $display("FAIL sim_i_done: got im/dm %b expected 10", {bus.im_done, bus.dm_done}); end
    checks++; if (bus.rdata !== 32'h11) begin errors++; $display("FAIL sim_i_rdata: got %h expected 00000011", bus.rdata); end
    bus.im_req = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    logic [AW-1:0] exp_addr;
    int n;
    bus.im_addr = 32'h500; bus.dm_addr = 32'h600; bus.dm_we = 1'b0;
    bus.im_req = 1'b1; bus.dm_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      tick();
      bus.dm_req = 1'b1;
      while (bus.mem_req !== 1'b1 && n < 5) begin
        tick();
        n++;
      end
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fair_grant%0d_timeout: got mem_req %b expected 1 within 5 cycles", g, bus.mem_req); end
      exp_addr = (g % 2 == 0) ? 32'h600 : 32'h500;
      checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL fair_grant%0d_addr: got %h expected %h", g, bus.mem_addr, exp_addr); end
      mem_respond(0, DW'(g));
      checks++; if ({bus.im_done, bus.dm_done} !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL fair_done%0d: got im/dm %b expected %b", g, {bus.im_done, bus.dm_done}, (g % 2 == 0) ? 2'b01 : 2'b10); end
      if (g % 2 == 0) bus.dm_req = 1'b0;
    end
    bus.im_req = 1'b0; bus.dm_req = 1'b0;
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fair_idle: got %b expected 0", bus.mem_req); end
  endtask

  task automatic test_write();
    bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_req = 1'b1;
    tick();
    // requester changes mid-grant must not reach the memory port
    bus.dm_addr = 32'h44; bus.dm_wdata = 32'h1234_5678; bus.dm_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus.mem_req, bus.mem_we, bus.dm_done} !== 3'b110) begin errors++; $display("FAIL wr_ctl%0d: got req/we/done %b expected 110", i, {bus.mem_req, bus.mem_we, bus.dm_done}); end
      checks++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h40, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_data%0d: got %h/%h expected 00000040/deadbeef", i, bus.mem_addr, bus.mem_wdata); end
      tick();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_0000;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if ({bus.dm_done, bus.im_done, bus.mem_err, bus.mem_req} !== 4'b1000) begin errors++; $display("FAIL wr_done: got dm/im/err/req %b expected 1000", {bus.dm_done, bus.im_done, bus.mem_err, bus.mem_req}); end
    checks++; if (bus.rdata !== 32'hCAFE_0000) begin errors++; $display("FAIL wr_rdata: got %h expected cafe0000", bus.rdata); end
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bus.im_addr = 32'h700; bus.im_req = 1'b1;
    tick();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL tmo_grant: got %b expected 1", bus.mem_req); end
    for (int i = 1; i <= TMO; i++) begin
      tick();
      checks++; if ({bus.mem_req, bus.im_done, bus.mem_err} !== 3'b100) begin errors++; $display("FAIL tmo_wait%0d: got req/done/err %b expected 100", i, {bus.mem_req, bus.im_done, bus.mem_err}); end
    end
    tick();
    checks++; if ({bus.mem_req, bus.im_done, bus.mem_err, bus.dm_done} !== 4'b0110) begin errors++; $display("FAIL tmo_fire: got req/im/err/dm %b expected 0110", {bus.mem_req, bus.im_done, bus.mem_err, bus.dm_done}); end
    checks++; if (bus.rdata !== 32'hCAFE_0000) begin errors++; $display("FAIL tmo_rdata_kept: got %h expected cafe0000", bus.rdata); end
    bus.im_req = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if ({bus.mem_req, bus.im_done, bus.dm_done, bus.mem_err} !== 4'b0000) begin errors++; $display("FAIL tmo_late_ctl: got req/im/dm/err %b expected 0000", {bus.mem_req, bus.im_done, bus.dm_done, bus.mem_err}); end
    checks++; if (bus.rdata !== 32'hCAFE_0000) begin errors++; $display("FAIL tmo_late_rdata: got %h expected cafe0000", bus.rdata); end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bus.dm_we = 1'b0; bus.dm_addr = 32'h900; bus.dm_req = 1'b1;
    tick();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmid_grant: got %b expected 1", bus.mem_req); end
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({bus.mem_req, bus.dm_done} !== 2'b00) begin errors++; $display("FAIL rmid_async: got req/done %b expected 00", {bus.mem_req, bus.dm_done}); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr: got %h expected 0", bus.mem_addr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({bus.mem_req, bus.dm_done} !== 2'b00) begin errors++; $display("FAIL rmid_hold%0d: got req/done %b expected 00", i, {bus.mem_req, bus.dm_done}); end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if ({bus.mem_req, bus.dm_done} !== 2'b10) begin errors++; $display("FAIL rmid_regrant: got req/done %b expected 10", {bus.mem_req, bus.dm_done}); end
    checks++; if (bus.mem_addr !== 32'h900) begin errors++; $display("FAIL rmid_addr2: got %h expected 00000900", bus.mem_addr); end
    mem_respond(0, 32'h77);
    checks++; if ({bus.dm_done, bus.rdata} !== {1'b1, 32'h77}) begin errors++; $display("FAIL rmid_done: got %b/%h expected 1/00000077", bus.dm_done, bus.rdata); end
    bus.dm_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_i_miss();
    test_simultaneous();
    test_fairness();
    test_write();
    test_timeout();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, the maximum number of cycles a grant waits for mem_ready.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
  clk  in  1  rising-edge clock.
  rst  in  1  asynchronous, active-low reset.
  im_req  in  1  I-cache refill request, level, held until im_done.
  im_addr  in  ADDR_W  I-cache refill address.
  dm_req  in  1  D-cache request, level, held until dm_done.
  dm_we  in  1  D-cache write (1) or read (0).
  dm_addr  in  ADDR_W  D-cache address.
  dm_wdata  in  DATA_W  D-cache write data.
  mem_ready  in  1  memory completion pulse, one cycle.
  mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
  mem_req  out  1  memory access request.
  mem_we  out  1  memory write strobe.
  mem_addr  out  ADDR_W  memory address.
  mem_wdata  out  DATA_W  memory write data.
  im_done  out  1  I-side completion pulse.
  dm_done  out  1  D-side completion pulse.
  rdata  out  DATA_W  captured read data, valid with either done.
  mem_err  out  1  timeout pulse, coincident with the done pulse.
  stall_cache  out  1  pipeline hold for the IF/ID and later stage registers.

Function
REQ-006 SHALL implement states IDLE, GNT_I and GNT_D.
REQ-007 In IDLE, when a request is eligible, the block SHALL on the next edge latch mem_addr, mem_we and mem_wdata from the granted requester, set mem_req=1 and enter GNT_x.
REQ-008 A request SHALL be eligible only while its done output is low, so a stale request in its done cycle is ignored.
REQ-009 Arbitration with a single eligible request SHALL grant that request.
REQ-010 Arbitration with both requests eligible SHALL grant the side not served last (last_gnt flag); after reset last_gnt=I, so D wins first.
REQ-011 For an I grant, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-012 In GNT_x, mem_req, mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ready.
REQ-013 On mem_ready in GNT_x, the next edge SHALL perform all of the following:
  - rdata <= mem_rdata (for a write too);
  - x_done=1 for exactly one cycle;
  - mem_req=0;
  - last_gnt <= x;
  - return to IDLE.
REQ-014 mem_ready in IDLE SHALL be ignored.
REQ-015 Minimum latency SHALL be: req sampled at edge N, mem_req high after edge N; mem_ready in cycle N+k gives done high after edge N+k+1.
REQ-016 Back-to-back grants SHALL have mem_req low for at least one cycle between grants (the done cycle).
REQ-017 A wait counter SHALL clear on grant and increment each GNT_x cycle without mem_ready.
REQ-018 When the wait counter reaches TIMEOUT, the next edge SHALL pulse x_done and mem_err together, leave rdata unchanged, drop mem_req and return to IDLE.
REQ-019 A late mem_ready arriving after a timeout SHALL be ignored.
REQ-020 stall_cache SHALL be combinational: (im_req & ~im_done) | (dm_req & ~dm_done).
REQ-021 stall_cache SHALL therefore be low in the done cycle when the other request is idle, so the pipeline advances that cycle.
REQ-022 Requester inputs SHALL be sampled only in IDLE; changes to address or data during a grant have no effect.

Reset
REQ-023 While rst=0, the block SHALL immediately force:
  - state=IDLE;
  - mem_req, mem_we, im_done, dm_done, mem_err = 0;
  - mem_addr, mem_wdata, rdata = 0;
  - wait counter = 0;
  - last_gnt = I.
REQ-024 Reset mid-grant SHALL abort the transaction with no done pulse; the memory side tolerates a dropped mem_req.
REQ-025 On the first edge after rst rises, the block SHALL arbitrate normally.

Verification
REQ-026 Directed scenario, single I miss:
  - stimulus: im_req=1 with im_addr=0x100; memory answers 3 cycles after mem_req with rdata 0x00000013;
  - required: mem_addr=0x100 and mem_we=0; im_done pulses once with rdata=0x13; stall_cache is high from the request until the im_done cycle.
REQ-027 Directed scenario, simultaneous requests after reset:
  - stimulus: im_req and dm_req (read at 0x2000) rise in the same cycle;
  - required: D granted first; I granted next, with mem_req low for one cycle between grants; stall_cache stays high throughout.
REQ-028 Directed scenario, fairness:
  - stimulus: dm_req re-asserts immediately after every dm_done while im_req is held high;
  - required: grants alternate D, I, D, I.
REQ-029 Directed scenario, write:
  - stimulus: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF;
  - required: mem_we=1 and mem_wdata=0xDEADBEEF are held stable until mem_ready; then dm_done pulses.
REQ-030 Directed scenario, timeout (TIMEOUT=8):
  - stimulus: mem_ready never asserts; a late mem_ready arrives afterwards;
  - required: done and mem_err pulse together 9 cycles after grant; mem_req drops; the late mem_ready is ignored.
REQ-031 Directed scenario, reset mid-grant:
  - stimulus: rst=0 in GNT_D;
  - required: mem_req=0 immediately; no dm_done; after release with dm_req still high, a fresh grant occurs.
